// File: rtl/clock_controller_if.sv
// Control and status bundle between the front panel / CPU and clock_controller.
// The controller connects through the slave modport; the panel or bench drives the master side.
interface clock_controller_if #(
  parameter int DIV_W   = 16,
  parameter int BURST_W = 8
);
  logic [1:0]         mode;
  logic               manual_pulse;
  logic               div_load;
  logic [DIV_W-1:0]   div_value;
  logic [BURST_W-1:0] burst_len;
  logic               halt;
  logic               resume;
  logic               cpu_tick;
  logic               pulse_clean;
  logic               halted;
  logic [BURST_W-1:0] burst_left;

  modport master (
    output mode, manual_pulse, div_load, div_value, burst_len, halt, resume,
    input  cpu_tick, pulse_clean, halted, burst_left
  );

  modport slave (
    input  mode, manual_pulse, div_load, div_value, burst_len, halt, resume,
    output cpu_tick, pulse_clean, halted, burst_left
  );
endinterface

// File: rtl/clock_controller.sv
// CPU clock-enable generator: debounced step button, run-rate divider and halt latch, all on system_clock.
// Burst mode (N divided ticks per button press) is compiled in only when CLOCK_CONTROLLER_BURST_EN is defined.
module clock_controller #(
  parameter int          DIV_W     = 16,
  parameter int          DEB_W     = 8,
  parameter int          BURST_W   = 8,
  parameter int unsigned DIV_RESET = 0
) (
  input  logic              system_clock,
  input  logic              system_reset_n,
  clock_controller_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_STOP  = 2'd0,
    MODE_RUN   = 2'd1,
    MODE_STEP  = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  localparam logic [DEB_W-1:0] DEB_MAX = {DEB_W{1'b1}};
  localparam logic [DEB_W-1:0] DEB_ONE = DEB_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  mode_e              mode;
  mode_e              mode_prev;
  logic               sync_1;
  logic               sync_2;
  logic [DEB_W-1:0]   deb;
  logic               pulse_clean;
  logic               pulse_prev;
  logic               step_req;
  logic [DIV_W-1:0]   div_reg;
  logic [DIV_W-1:0]   dcnt;
  logic [BURST_W-1:0] burst_left;
  logic               halted;
  logic               cpu_tick;
  logic               mode_changed;
  logic               burst_active;
  logic               div_running;
  logic               div_clear;
  logic               div_hit;
  logic               tick_source;

  assign mode         = mode_e'(bus.mode);
  assign mode_changed = (mode != mode_prev);

  // The button is asynchronous and bouncy: two flops, then an up/down integrator whose
  // output only flips at the rails, so bounce shorter than the integrator span is absorbed.
  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      sync_1      <= 1'b0;
      sync_2      <= 1'b0;
      deb         <= '0;
      pulse_clean <= 1'b0;
      pulse_prev  <= 1'b0;
      step_req    <= 1'b0;
    end else begin
      sync_1 <= bus.manual_pulse;
      sync_2 <= sync_1;
      if (sync_2 && (deb != DEB_MAX)) begin
        deb <= deb + DEB_ONE;
      end else if (!sync_2 && (deb != '0)) begin
        deb <= deb - DEB_ONE;
      end
      if (deb == DEB_MAX) begin
        pulse_clean <= 1'b1;
      end else if (deb == '0) begin
        pulse_clean <= 1'b0;
      end
      pulse_prev <= pulse_clean;
      step_req   <= pulse_clean & ~pulse_prev;
    end
  end

`ifdef CLOCK_CONTROLLER_BURST_EN
  assign burst_active = (mode == MODE_BURST) && (burst_left != '0);
`else
  assign burst_active = 1'b0;
`endif

  // The divider restarts from zero whenever its phase would be meaningless, so the first
  // tick after entering RUN, loading a burst or resuming always lands div_reg + 1 cycles later.
  assign div_running = (mode == MODE_RUN) || burst_active;
  assign div_clear   = bus.div_load | mode_changed | ~div_running | bus.halt | halted;
  assign div_hit     = ~div_clear & (dcnt == div_reg);

  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      div_reg   <= DIV_W'(DIV_RESET);
      dcnt      <= '0;
      mode_prev <= MODE_STOP;
    end else begin
      mode_prev <= mode;
      if (bus.div_load) begin
        div_reg <= bus.div_value;
      end
      if (div_clear || div_hit) begin
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + DIV_ONE;
      end
    end
  end

`ifdef CLOCK_CONTROLLER_BURST_EN
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

  // A press only arms a burst when none is running; halt or a mode change abandons it.
  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      burst_left <= '0;
    end else if (bus.halt || mode_changed) begin
      burst_left <= '0;
    end else if ((mode == MODE_BURST) && step_req && (burst_left == '0) && !halted) begin
      burst_left <= bus.burst_len;
    end else if (burst_active && div_hit) begin
      burst_left <= burst_left - BURST_ONE;
    end
  end
`else
  logic unused_burst_len;

  assign burst_left       = '0;
  assign unused_burst_len = ^bus.burst_len;
`endif

  always_comb begin
    tick_source = 1'b0;
    case (mode)
      MODE_STOP:  tick_source = 1'b0;
      MODE_RUN:   tick_source = div_hit;
      MODE_STEP:  tick_source = step_req;
      MODE_BURST: begin
`ifdef CLOCK_CONTROLLER_BURST_EN
        tick_source = burst_active & div_hit;
`else
        tick_source = step_req;
`endif
      end
      default:    tick_source = 1'b0;
    endcase
  end

  // Halt wins over resume, and a tick arriving while halting or halted is dropped, not queued.
  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      halted   <= 1'b0;
      cpu_tick <= 1'b0;
    end else begin
      if (bus.halt) begin
        halted <= 1'b1;
      end else if (bus.resume) begin
        halted <= 1'b0;
      end
      cpu_tick <= tick_source & ~bus.halt & ~halted;
    end
  end

  assign bus.cpu_tick    = cpu_tick;
  assign bus.pulse_clean = pulse_clean;
  assign bus.halted      = halted;
  assign bus.burst_left  = burst_left;

endmodule

// File: tb/tb_clock_controller.sv
// Self-checking bench for clock_controller: directed scenarios with fixed expectations plus
// randomized traffic checked every cycle against a behavioural model of the controller.
module tb_clock_controller;

  localparam int DIV_W   = 16;
  localparam int DEB_W   = 8;
  localparam int BURST_W = 8;
  localparam int DEB_MAX = (1 << DEB_W) - 1;
`ifdef CLOCK_CONTROLLER_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  logic system_clock = 1'b0;
  logic system_reset_n;

  clock_controller_if #(.DIV_W(DIV_W), .BURST_W(BURST_W)) bus ();

  clock_controller #(
    .DIV_W    (DIV_W),
    .DEB_W    (DEB_W),
    .BURST_W  (BURST_W),
    .DIV_RESET(0)
  ) dut (
    .system_clock  (system_clock),
    .system_reset_n(system_reset_n),
    .bus           (bus)
  );

  always #5 system_clock = ~system_clock;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  // Reference model state, in spec terms: synchroniser samples, integrator level, clean
  // level and its previous value, pending step, divider period and cycles since restart.
  int m_s1, m_s2, m_deb, m_clean, m_clean_prev, m_step;
  int m_div, m_since, m_mode_prev, m_burst, m_halted, m_tick;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  task automatic modelReset();
    m_s1 = 0; m_s2 = 0; m_deb = 0; m_clean = 0; m_clean_prev = 0; m_step = 0;
    m_div = 0; m_since = 0; m_mode_prev = 0; m_burst = 0; m_halted = 0; m_tick = 0;
  endtask

  task automatic modelStep();
    int  mode_i;
    bit  changed, running, restart, hit, src;
    int  n_deb, n_clean, n_step, n_burst, n_halted;
    mode_i  = int'(bus.mode);
    changed = (mode_i != m_mode_prev);
    running = (mode_i == 1) || (BURST_EN && mode_i == 3 && m_burst != 0);
    restart = bus.div_load || changed || !running || bus.halt || (m_halted != 0);
    hit     = !restart && ((m_since % (m_div + 1)) == m_div);
    case (mode_i)
      1:       src = hit;
      2:       src = (m_step != 0);
      3:       src = BURST_EN ? (hit && m_burst != 0) : (m_step != 0);
      default: src = 1'b0;
    endcase
    if (!BURST_EN || bus.halt || changed)                                n_burst = 0;
    else if (mode_i == 3 && m_step != 0 && m_burst == 0 && m_halted == 0) n_burst = int'(bus.burst_len);
    else if (mode_i == 3 && m_burst != 0 && hit)                          n_burst = m_burst - 1;
    else                                                                  n_burst = m_burst;
    n_halted = bus.halt ? 1 : (bus.resume ? 0 : m_halted);
    n_deb    = (m_s2 != 0) ? ((m_deb < DEB_MAX) ? m_deb + 1 : DEB_MAX) : ((m_deb > 0) ? m_deb - 1 : 0);
    n_clean  = (m_deb == DEB_MAX) ? 1 : ((m_deb == 0) ? 0 : m_clean);
    n_step   = (m_clean != 0 && m_clean_prev == 0) ? 1 : 0;
    m_tick       = (src && !bus.halt && m_halted == 0) ? 1 : 0;
    m_since      = restart ? 0 : m_since + 1;
    m_burst      = n_burst;
    m_halted     = n_halted;
    m_clean_prev = m_clean;
    m_clean      = n_clean;
    m_step       = n_step;
    m_deb        = n_deb;
    m_s2         = m_s1;
    m_s1         = int'(bus.manual_pulse);
    if (bus.div_load) m_div = int'(bus.div_value);
    m_mode_prev  = mode_i;
  endtask

  task automatic runCycle();
    @(posedge system_clock);
    modelStep();
    cycle++;
    #1;
    checkOutput("cpu_tick",    bus.cpu_tick,    m_tick);
    checkOutput("pulse_clean", bus.pulse_clean, m_clean);
    checkOutput("halted",      bus.halted,      m_halted);
    checkOutput("burst_left",  bus.burst_left,  m_burst);
  endtask

  task automatic applyStimulus(input int mode_v, input bit pulse_v, input int cycles);
    bus.mode         = 2'(mode_v);
    bus.manual_pulse = pulse_v;
    for (int i = 0; i < cycles; i++) runCycle();
  endtask

  task automatic loadDivider(input int value);
    bus.div_value = DIV_W'(value);
    bus.div_load  = 1'b1;
    runCycle();
    bus.div_load  = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_tick"},   bus.cpu_tick,    0);
    checkOutput({tag, "_clean"},  bus.pulse_clean, 0);
    checkOutput({tag, "_halted"}, bus.halted,      0);
    checkOutput({tag, "_burst"},  bus.burst_left,  0);
  endtask

  // Presses/releases the button in phases and reports ticks seen, first/last tick index, peak burst_left.
  task automatic countTicks(input int press, input int release_c, output int ticks, output int first,
                            output int last, output int peak);
    ticks = 0; first = -1; last = -1; peak = 0;
    for (int e = 1; e <= press + release_c; e++) begin
      bus.manual_pulse = (e <= press);
      runCycle();
      if (bus.cpu_tick === 1'b1) begin
        ticks++;
        if (first < 0) first = e;
        last = e;
      end
      if (int'(bus.burst_left) > peak) peak = int'(bus.burst_left);
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ticks, first, last, peak, t2, f2, l2, p2, seg_len;
    bit found, bouncy, level;

    bus.mode = 2'd0; bus.manual_pulse = 1'b0; bus.div_load = 1'b0; bus.div_value = '0;
    bus.burst_len = '0; bus.halt = 1'b0; bus.resume = 1'b0;
    system_reset_n = 1'b1;
    #2 system_reset_n = 1'b0;
    #1 checkResetOutputs("reset_async");
    repeat (2) begin
      @(posedge system_clock);
      #1 checkResetOutputs("reset_hold");
    end
    modelReset();
    #4 system_reset_n = 1'b1;

    $display("[TB] RUN with div_value 3");
    loadDivider(3);
    bus.mode = 2'd1;
    for (int n = 0; n <= 12; n++) begin
      runCycle();
      checkOutput("run_period", bus.cpu_tick, (n > 0) && (n % 4 == 0));
    end

    $display("[TB] bouncy button in STEP");
    bus.mode = 2'd2;
    for (int n = 0; n < 100; n++) begin
      bus.manual_pulse = (n % 2 == 0);
      runCycle();
    end
    countTicks(300, 0, ticks, first, last, peak);
    checkOutput("button_ticks", ticks, 1);
    checkOutput("button_latency", first, 260);
    countTicks(0, 50, ticks, first, last, peak);
    countTicks(300, 300, t2, f2, l2, p2);
    checkOutput("button_repress", ticks + t2, 0);
    checkOutput("button_release", bus.pulse_clean, 0);

    $display("[TB] BURST of 5 with div_value 1");
    loadDivider(1);
    bus.burst_len = 8'd5;
    bus.mode = 2'd3;
    countTicks(300, 300, ticks, first, last, peak);
    checkOutput("burst_ticks", ticks, BURST_EN ? 5 : 1);
    checkOutput("burst_span", last - first, BURST_EN ? 8 : 0);
    checkOutput("burst_peak", peak, BURST_EN ? 5 : 0);

    $display("[TB] long BURST with a second press mid-burst");
    loadDivider(3);
    bus.burst_len = 8'd255;
    countTicks(300, 300, ticks, first, last, peak);
    countTicks(300, 700, t2, f2, l2, p2);
    checkOutput("burst_second_press", ticks + t2, BURST_EN ? 255 : 2);

    $display("[TB] halt and resume in RUN with div_value 0");
    loadDivider(0);
    bus.mode = 2'd1;
    repeat (3) runCycle();
    checkOutput("halt_pre_tick", bus.cpu_tick, 1);
    bus.halt = 1'b1;
    runCycle();
    bus.halt = 1'b0;
    checkOutput("halt_tick", bus.cpu_tick, 0);
    checkOutput("halt_latch", bus.halted, 1);
    repeat (2) runCycle();
    checkOutput("halt_held_tick", bus.cpu_tick, 0);
    bus.halt = 1'b1; bus.resume = 1'b1;
    runCycle();
    bus.halt = 1'b0;
    checkOutput("halt_wins", bus.halted, 1);
    runCycle();
    checkOutput("resume_clear", bus.halted, 0);
    checkOutput("resume_first_tick", bus.cpu_tick, 0);
    bus.resume = 1'b0;
    runCycle();
    checkOutput("resume_restart", bus.cpu_tick, 1);

    $display("[TB] mid-burst switch to RUN");
    loadDivider(1);
    bus.burst_len = 8'd9;
    bus.mode = 2'd3;
    bus.manual_pulse = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      runCycle();
      if (int'(bus.burst_left) == (BURST_EN ? 3 : 0)) found = 1'b1;
    end
    checkOutput("abort_wait", found, 1);
    bus.mode = 2'd1;
    for (int n = 0; n <= 6; n++) begin
      runCycle();
      if (n == 0) checkOutput("abort_clear", bus.burst_left, 0);
      checkOutput("abort_run", bus.cpu_tick, (n > 0) && (n % 2 == 0));
    end
    applyStimulus(0, 1'b0, 300);

    $display("[TB] asynchronous reset mid-burst");
    loadDivider(1);
    bus.burst_len = 8'd20;
    bus.mode = 2'd3;
    bus.manual_pulse = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      runCycle();
      if (bus.pulse_clean === 1'b1 && int'(bus.burst_left) == (BURST_EN ? 10 : 0)) found = 1'b1;
    end
    checkOutput("midburst_wait", found, 1);
    #2 system_reset_n = 1'b0;
    #1 checkResetOutputs("reset_midburst");
    bus.mode = 2'd0; bus.manual_pulse = 1'b0;
    repeat (2) @(posedge system_clock);
    modelReset();
    #3 system_reset_n = 1'b1;

    $display("[TB] randomized traffic against the model");
    for (int seg = 0; seg < 30; seg++) begin
      seg_len       = $urandom_range(40, 400);
      bouncy        = ($urandom_range(0, 3) == 0);
      level         = $urandom_range(0, 1);
      bus.mode      = 2'($urandom_range(0, 3));
      bus.burst_len = 8'($urandom_range(0, 6));
      for (int c = 0; c < seg_len; c++) begin
        bus.manual_pulse = bouncy ? 1'($urandom_range(0, 1)) : level;
        bus.halt         = ($urandom_range(0, 59) == 0);
        bus.resume       = ($urandom_range(0, 14) == 0);
        bus.div_load     = ($urandom_range(0, 79) == 0);
        bus.div_value    = DIV_W'($urandom_range(0, 4));
        runCycle();
      end
    end
    bus.halt = 1'b0; bus.resume = 1'b0; bus.div_load = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_controller.md
# clock_controller

Parametrised CPU clock generator for the breadboard-style computer: turns the board's single system clock into a one-cycle CPU clock-enable tick. It replaces the fixed auto/manual gated clock. Additions over the old block: a programmable run-rate divider, a configurable-width debounce integrator with hysteresis, a latched halt with explicit resume, and an optional N-step burst mode. All downstream registers advance on `system_clock` qualified by `cpu_tick`; nothing is clocked by a derived clock.

## Interface
- `DIV_W`, 16: divider reload register width.
- `DEB_W`, 8: debounce integrator width.
- `BURST_W`, 8: burst length width.
- `DIV_RESET`, 0: divider value loaded at reset.

Ports:
- `system_clock`  in  1  sole clock; all state on its rising edge.
- `system_reset_n`  in  1  asynchronous, active-low reset.
- `mode`  in  2  0 STOP, 1 RUN, 2 STEP, 3 BURST.
- `manual_pulse`  in  1  raw push-button, asynchronous and bouncy.
- `div_load`  in  1  load `div_value` into divider register.
- `div_value`  in  DIV_W  tick period minus one for RUN/BURST.
- `burst_len`  in  BURST_W  ticks per burst.
- `halt`  in  1  CPU HLT control line; level, sampled.
- `resume`  in  1  clears the halted latch.
- `cpu_tick`  out  1  registered one-cycle clock enable to the CPU.
- `pulse_clean`  out  1  debounced button level.
- `halted`  out  1  halt latch.
- `burst_left`  out  BURST_W  remaining burst ticks.

## Operation
- **Input synchroniser:** `manual_pulse` goes through a 2-flop synchroniser before the integrator.
- **Debounce integrator** (DEB_W-bit counter, `deb`):
  - synchronised input 1: `deb` increments, saturating at all-ones.
  - synchronised input 0: `deb` decrements, saturating at 0.
  - `pulse_clean` sets on the edge where `deb` is all-ones and clears on the edge where `deb` is 0; otherwise it holds (hysteresis).
  - A registered rising-edge detect on `pulse_clean` produces `step_req`, one cycle wide.
- **Divider:**
  - `div_reg` loads on `div_load`.
  - Counter `dcnt` counts 0..`div_reg`. The edge where `dcnt == div_reg` emits `div_hit` and wraps `dcnt` to 0.
  - `dcnt` clears on `div_load`, on any `mode` change, and while neither RUN nor an active burst is running.
  - `div_reg = 0` gives `div_hit` every cycle.
- **Tick source by mode:**
  - STOP: none.
  - RUN: `div_hit`.
  - STEP: `step_req`.
  - BURST: `step_req` with `burst_left == 0` loads `burst_left = burst_len`. While `burst_left != 0`, each `div_hit` ticks and decrements `burst_left`.
- **Halt:**
  - `halt` sampled 1 sets `halted`. `resume` sampled 1 clears it. Both asserted: `halt` wins.
  - `cpu_tick <= source & ~halt & ~halted`, so a tick is suppressed in the same cycle `halt` is sampled high.
  - A tick suppressed by halt is lost, not queued.
  - Setting `halted` clears `burst_left` and `dcnt`.
- **Burst boundaries:**
  - `step_req` while a burst is active is ignored.
  - A `mode` change mid-burst clears `burst_left` to 0.
  - `burst_len = 0` produces no ticks.

## Timing
- **Reset values:** `cpu_tick` 0, `pulse_clean` 0, `halted` 0, `burst_left` 0, `div_reg = DIV_RESET`, `dcnt` 0, `deb` 0, synchroniser flops 0.
- **Reset:** asserting `system_reset_n` mid-operation aborts bursts and clears halt immediately; no tick is issued.
- **Button latency:** with `manual_pulse` held steady high, `cpu_tick` rises 2 (sync) + 2^DEB_W (integrate) + 1 (set) + 1 (edge/tick register) edges after the first sampling edge. That is 260 edges for DEB_W = 8.
- **Button release:** needs 2^DEB_W − 1 low-sampled cycles before `pulse_clean` clears; a re-press before then yields no tick.
- **RUN:** first tick `div_reg + 1` cycles after entering RUN; period `div_reg + 1` thereafter.
- **BURST:** first tick `div_reg + 1` cycles after the `burst_left` load; last tick coincides with `burst_left` reaching 0.
- `cpu_tick` is never high for two consecutive cycles unless `div_reg = 0` in RUN/BURST.

## Configuration
- `CLOCK_CONTROLLER_BURST_EN`
  - Defined: BURST mode and the `burst_left` counter as described.
  - Undefined: mode 3 behaves exactly as STEP, `burst_left` is tied to 0, and `burst_len` is ignored.

## Test plan
- **Reset, then RUN:** `div_value` = 3 loaded, mode 1 → `cpu_tick` high 4 cycles after entry, then every 4 cycles; all outputs 0 during and after reset.
- **Bouncy button, STEP, DEB_W = 8:** 100 cycles of alternating bounce then steady high → exactly one `cpu_tick`, 260 edges after the steady level is first sampled; release and re-press after 50 low cycles → no second tick.
- **BURST, `burst_len` = 5, `div_reg` = 1:** one step → 5 ticks 2 cycles apart; `burst_left` 5→0; a second step mid-burst is ignored. A build without the macro gives exactly 1 tick.
- **Halt:** in RUN with `div_reg` = 0, `halt` pulsed 1 cycle → `cpu_tick` 0 from that edge, `halted` = 1; `halt` and `resume` asserted together keep `halted` = 1; `resume` alone → ticks restart next cycle.
- **Mid-burst abort:** switch mode to RUN at `burst_left` = 3 → `burst_left` = 0 and `dcnt` cleared; RUN period restarts from 0.
- **Async reset mid-burst:** `system_reset_n` low mid-burst → all outputs 0 without waiting for a clock edge.
